// File: rtl/sprite_renderer_if.sv
// Raster-side and ROM-side bus of the sprite compositor.
// The master (timing generator / ROM) drives coordinates and ROM data; the slave (sprite_renderer) drives the address and pixels.
interface sprite_renderer_if #(
  parameter int ADDR_W = 16,
  parameter int CW     = 8
);
  logic [9:0]        x;
  logic [9:0]        y;
  logic              frame_start;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              pos_load;
  logic [1:0]        scale;
  logic              transp_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3*CW-1:0]   mem_rdata;
  logic [CW-1:0]     vga_red;
  logic [CW-1:0]     vga_green;
  logic [CW-1:0]     vga_blue;
  logic              hit;

  modport master (
    output x, y, frame_start, pos_x, pos_y, pos_load, scale, transp_en, mem_rdata,
    input  mem_addr, vga_red, vga_green, vga_blue, hit
  );

  modport slave (
    input  x, y, frame_start, pos_x, pos_y, pos_load, scale, transp_en, mem_rdata,
    output mem_addr, vga_red, vga_green, vga_blue, hit
  );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite compositor: raster coordinate -> ROM address -> keyed RGB, fixed 2+MEM_LAT latency.
// The origin is double-buffered so a moving sprite only changes position at frame_start.
module sprite_renderer #(
  parameter int              SPR_W   = 224,
  parameter int              SPR_H   = 180,
  parameter int              ADDR_W  = 16,
  parameter int              CW      = 8,
  parameter int              MEM_LAT = 1,
  parameter logic [9:0]      DEF_X   = 10'd150,
  parameter logic [9:0]      DEF_Y   = 10'd100,
  parameter logic [3*CW-1:0] KEY     = 24'hFF00FF,
  parameter logic [3*CW-1:0] BG      = 24'h000000
) (
  input logic               clk,
  input logic               rst,
  sprite_renderer_if.slave  bus
);

  localparam logic [12:0]       W_BASE   = 13'(SPR_W);
  localparam logic [12:0]       H_BASE   = 13'(SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A  = ADDR_W'(SPR_W);

  logic [9:0]        pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_LAT:0]  box_q, box_d;
  logic [3*CW-1:0]   rgb_q, rgb_d;
  logic              hit_q, hit_d;

  logic signed [10:0] dx_s, dy_s;
  logic [12:0]        w_lim_s, h_lim_s;
  logic [9:0]         col_s, row_s;
  logic               in_box_s;

  // Pending/active origin: a load coincident with frame_start bypasses pending.
  always_comb begin
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    if (bus.pos_load) begin
      pend_x_d = bus.pos_x;
      pend_y_d = bus.pos_y;
    end else begin
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
    end
    if (bus.frame_start) begin
      act_x_d = pend_x_d;
      act_y_d = pend_y_d;
    end else begin
      act_x_d = act_x_q;
      act_y_d = act_y_q;
    end
  end

  // Box test and address; 11-bit signed deltas keep a clipped sprite from wrapping.
  always_comb begin
    dx_s     = $signed({1'b0, bus.x}) - $signed({1'b0, act_x_q});
    dy_s     = $signed({1'b0, bus.y}) - $signed({1'b0, act_y_q});
    w_lim_s  = W_BASE << bus.scale;
    h_lim_s  = H_BASE << bus.scale;
    col_s    = dx_s[9:0] >> bus.scale;
    row_s    = dy_s[9:0] >> bus.scale;
    in_box_s = !dx_s[10] && ({3'b000, dx_s[9:0]} < w_lim_s) &&
               !dy_s[10] && ({3'b000, dy_s[9:0]} < h_lim_s);
    if (in_box_s) begin
      mem_addr_d = ADDR_W'(row_s) * SPR_W_A + ADDR_W'(col_s);
    end else begin
      mem_addr_d = mem_addr_q;
    end
    box_d = {box_q[MEM_LAT-1:0], in_box_s};
  end

  // Output select against the in_box bit aligned with the ROM data.
  always_comb begin
    if (box_q[MEM_LAT] && !(bus.transp_en && (bus.mem_rdata == KEY))) begin
      rgb_d = bus.mem_rdata;
      hit_d = 1'b1;
    end else begin
      rgb_d = BG;
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_x_q   <= DEF_X;
      pend_y_q   <= DEF_Y;
      act_x_q    <= DEF_X;
      act_y_q    <= DEF_Y;
      mem_addr_q <= '0;
      box_q      <= '0;
      rgb_q      <= BG;
      hit_q      <= 1'b0;
    end else begin
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      mem_addr_q <= mem_addr_d;
      box_q      <= box_d;
      rgb_q      <= rgb_d;
      hit_q      <= hit_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.vga_red   = rgb_q[3*CW-1:2*CW];
  assign bus.vga_green = rgb_q[2*CW-1:CW];
  assign bus.vga_blue  = rgb_q[CW-1:0];
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a one-cycle synchronous ROM model.
module tb_sprite_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sprite_renderer_if #(.ADDR_W(16), .CW(8)) bus ();

  sprite_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [15:0] a);
    if (a == 16'd5) rom_f = 24'hFF00FF;
    else            rom_f = {a[15:8] ^ 8'hA5, a[7:0], 8'h5A};
  endfunction

  always @(posedge clk) bus.mem_rdata <= rom_f(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rgb();
    rgb = {bus.vga_red, bus.vga_green, bus.vga_blue};
  endfunction

  task automatic px(input logic [9:0] xi, input logic [9:0] yi);
    @(negedge clk);
    bus.x = xi;
    bus.y = yi;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(input string tag, input logic [15:0] addr, input logic h);
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({tag, ".hit"}, 32'(bus.hit), 32'(h));
    chk({tag, ".rgb"}, 32'(rgb()), h ? 32'(rom_f(addr)) : 32'h0);
  endtask

  task automatic origin(input logic [9:0] px_i, input logic [9:0] py_i,
                        input logic ld, input logic fs);
    @(negedge clk);
    bus.pos_x       = px_i;
    bus.pos_y       = py_i;
    bus.pos_load    = ld;
    bus.frame_start = fs;
    @(negedge clk);
    bus.pos_load    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.x = 10'd0; bus.y = 10'd0; bus.frame_start = 1'b0;
    bus.pos_x = 10'd0; bus.pos_y = 10'd0; bus.pos_load = 1'b0;
    bus.scale = 2'd0; bus.transp_en = 1'b0; bus.mem_rdata = 24'h0;
    #12;
    chk("rst.addr", 32'(bus.mem_addr), 32'h0);
    chk("rst.hit", 32'(bus.hit), 32'h0);
    chk("rst.rgb", 32'(rgb()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    px(10'd150, 10'd100);
    expect_pix("origin", 16'd0, 1'b1);
    chk("origin.rom0", 32'(rgb()), 32'hA5005A);

    // Latency: a miss presented now must reach the output on the third edge.
    @(negedge clk);
    bus.x = 10'd149;
    @(posedge clk); #1;
    chk("lat.e1", 32'(bus.hit), 32'h1);
    @(posedge clk); #1;
    chk("lat.e2", 32'(bus.hit), 32'h1);
    @(posedge clk); #1;
    chk("lat.e3", 32'(bus.hit), 32'h0);
    expect_pix("left", 16'd0, 1'b0);

    px(10'd373, 10'd279);
    expect_pix("corner", 16'd40319, 1'b1);
    px(10'd374, 10'd279);
    expect_pix("right", 16'd40319, 1'b0);
    px(10'd373, 10'd280);
    expect_pix("bottom", 16'd40319, 1'b0);

    bus.transp_en = 1'b1;
    px(10'd155, 10'd100);
    chk("key.addr", 32'(bus.mem_addr), 32'd5);
    chk("key.hit", 32'(bus.hit), 32'h0);
    chk("key.rgb", 32'(rgb()), 32'h000000);
    bus.transp_en = 1'b0;
    px(10'd155, 10'd100);
    chk("nokey.hit", 32'(bus.hit), 32'h1);
    chk("nokey.rgb", 32'(rgb()), 32'hFF00FF);

    origin(10'd0, 10'd0, 1'b1, 1'b1);
    bus.scale = 2'd1;
    px(10'd3, 10'd5);
    expect_pix("s1.pix", 16'd449, 1'b1);
    px(10'd447, 10'd5);
    expect_pix("s1.redge", 16'd671, 1'b1);
    px(10'd448, 10'd5);
    expect_pix("s1.out", 16'd671, 1'b0);
    bus.scale = 2'd0;

    origin(10'd400, 10'd300, 1'b1, 1'b0);
    px(10'd10, 10'd10);
    expect_pix("pend.old", 16'd2250, 1'b1);
    px(10'd400, 10'd300);
    expect_pix("pend.notyet", 16'd2250, 1'b0);
    origin(10'd0, 10'd0, 1'b0, 1'b1);
    px(10'd400, 10'd300);
    expect_pix("pend.applied", 16'd0, 1'b1);

    origin(10'd1000, 10'd1000, 1'b1, 1'b1);
    px(10'd1023, 10'd1023);
    expect_pix("clip.corner", 16'd5175, 1'b1);
    px(10'd0, 10'd0);
    expect_pix("clip.nowrap", 16'd5175, 1'b0);

    px(10'd1010, 10'd1010);
    expect_pix("pre_rst", 16'd2250, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst.hit", 32'(bus.hit), 32'h0);
    chk("arst.rgb", 32'(rgb()), 32'h0);
    chk("arst.addr", 32'(bus.mem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    px(10'd150, 10'd100);
    expect_pix("rst.defpos", 16'd0, 1'b1);
    origin(10'd0, 10'd0, 1'b0, 1'b1);
    px(10'd150, 10'd100);
    expect_pix("rst.defpend", 16'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
